// File: rtl/seqgen_tx.sv
`default_nettype none
// ==== seqgen_tx: sync preamble + MSB-first payload serial transmitter; SEQGEN_PARITY_EN adds even parity | rev 1.0 ====
module seqgen_tx #(
  parameter int         DATA_W     = 8,
  parameter logic [7:0] PREAMBLE   = 8'b01000010,
  parameter logic       IDLE_LEVEL = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [DATA_W-1:0] Data,
  output logic              Ready,
  output logic              Out,
  output logic              Done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRE   = 2'd1;
  localparam logic [1:0] S_PAY   = 2'd2;
`ifdef SEQGEN_PARITY_EN
  localparam logic [1:0] S_PAR   = 2'd3;
`endif
  localparam logic [3:0] CNT_PRE = 4'd7;
  localparam logic [3:0] CNT_PAY = 4'(DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              out_q, out_d;
  logic              done_q, done_d;
`ifdef SEQGEN_PARITY_EN
  logic              par_q, par_d;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      out_q   <= IDLE_LEVEL;
      done_q  <= 1'b0;
`ifdef SEQGEN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      out_q   <= out_d;
      done_q  <= done_d;
`ifdef SEQGEN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // state_q/cnt_q describe the bit currently on Out; Ready is high only in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
`ifdef SEQGEN_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_PRE;
          cnt_d   = CNT_PRE;
          shift_d = Data;
`ifdef SEQGEN_PARITY_EN
          par_d   = ^Data;
`endif
        end
      end
      S_PRE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_PAY;
          cnt_d   = CNT_PAY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_PAY: begin
        shift_d = shift_q << 1;
        if (cnt_q == 4'd0) begin
`ifdef SEQGEN_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_IDLE;
`endif
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef SEQGEN_PARITY_EN
      S_PAR: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Out/Done are registered copies of the bit selected by the next state
  always_comb begin
    out_d  = IDLE_LEVEL;
    done_d = 1'b0;
    Ready  = (state_q == S_IDLE);
    case (state_d)
      S_PRE: out_d = PREAMBLE[cnt_d[2:0]];
      S_PAY: begin
        out_d = shift_d[DATA_W-1];
`ifndef SEQGEN_PARITY_EN
        done_d = (cnt_d == 4'd0);
`endif
      end
`ifdef SEQGEN_PARITY_EN
      S_PAR: begin
        out_d  = par_d;
        done_d = 1'b1;
      end
`endif
      default: out_d = IDLE_LEVEL;
    endcase
  end

  assign Out  = out_q;
  assign Done = done_q;

endmodule
`default_nettype wire
